// File: rtl/lsu_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // funct3[1:0] encodes the access size for both signed and unsigned forms
    function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] addr);
        case (funct3[1:0])
            2'b00:   be_gen = 4'b0001 << addr;
            2'b01:   be_gen = 4'b0011 << addr;
            default: be_gen = 4'b1111;
        endcase
    endfunction

    function automatic logic is_legal(input logic is_load, input logic [2:0] funct3,
                                      input logic [1:0] addr);
        logic f3_ok;
        logic aligned;
        if (is_load)
            f3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU);
        else
            f3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        case (funct3)
            F3_H, F3_HU: aligned = ~addr[0];
            F3_W:        aligned = (addr == 2'b00);
            default:     aligned = 1'b1;
        endcase
        is_legal = f3_ok & aligned;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the addressed lane of a read word and sign/zero-extends it.
module load_extract
    import lsu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] rdata,
    input  logic [2:0]   funct3,
    input  logic [1:0]   addr,
    output logic [N-1:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[8*addr +: 8];
        lane_h = addr[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{(N-8){lane_b[7]}}, lane_b};
            F3_BU:   data = {{(N-8){1'b0}}, lane_b};
            F3_H:    data = {{(N-16){lane_h[15]}}, lane_h};
            F3_HU:   data = {{(N-16){1'b0}}, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: dmem request/grant/response handshake,
// store lane replication, load extraction and pipeline stall.
module mem_access_unit
    import lsu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         MEMrdEn,
    input  logic         MEMwrEn,
    input  logic [2:0]   funct3,
    input  logic [N-1:0] ALUres,
    input  logic [N-1:0] RS2data,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [N-1:0] dmem_addr,
    output logic [3:0]   dmem_be,
    output logic [N-1:0] dmem_wdata,
    input  logic         dmem_gnt,
    input  logic         dmem_rvalid,
    input  logic [N-1:0] dmem_rdata,
    output logic [N-1:0] MEMread,
    output logic         stall,
    output logic         mem_err
);

    lsu_state_t  state, state_nxt;
    logic        access;
    logic        legal;
    logic        start;
    logic [2:0]  f3_q;
    logic [1:0]  alo_q;
    logic [N-1:0] wdata_rep;
    logic [N-1:0] load_word;

    assign access = MEMrdEn | MEMwrEn;
    assign legal  = is_legal(MEMrdEn, funct3, ALUres[1:0]);
    assign start  = (state == S_IDLE) & access & legal;

    always_comb begin
        case (funct3[1:0])
            2'b00:   wdata_rep = {4{RS2data[7:0]}};
            2'b01:   wdata_rep = {2{RS2data[15:0]}};
            default: wdata_rep = RS2data;
        endcase
    end

    load_extract #(.N(N)) u_extract (
        .rdata  (dmem_rdata),
        .funct3 (f3_q),
        .addr   (alo_q),
        .data   (load_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (access && legal) state_nxt = S_REQ;
            S_REQ:  if (dmem_gnt) state_nxt = dmem_we ? S_DONE : S_WAIT;
            S_WAIT: if (dmem_rvalid) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        stall   = start | (state == S_REQ) | (state == S_WAIT);
        mem_err = (state == S_IDLE) & access & ~legal;
    end

    // Request fields stay in their registers after the grant; only req drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= '0;
            f3_q       <= 3'b000;
            alo_q      <= 2'b00;
            MEMread    <= '0;
        end else begin
            if (start) begin
                dmem_req   <= 1'b1;
                dmem_we    <= ~MEMrdEn;
                dmem_addr  <= {ALUres[N-1:2], 2'b00};
                dmem_be    <= be_gen(funct3, ALUres[1:0]);
                dmem_wdata <= wdata_rep;
                f3_q       <= funct3;
                alo_q      <= ALUres[1:0];
            end else if ((state == S_REQ) && dmem_gnt) begin
                dmem_req   <= 1'b0;
            end
            if ((state == S_WAIT) && dmem_rvalid)
                MEMread <= load_word;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized checks of mem_access_unit against a behavioural LSU model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MEMrdEn, MEMwrEn;
    logic [2:0]  funct3;
    logic [31:0] ALUres, RS2data;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] MEMread;
    logic        stall, mem_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_mr = 32'h0;
    int          stall_cnt;

    mem_access_unit #(.N(32)) dut (
        .clk(clk), .rst_n(rst_n), .MEMrdEn(MEMrdEn), .MEMwrEn(MEMwrEn),
        .funct3(funct3), .ALUres(ALUres), .RS2data(RS2data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .MEMread(MEMread), .stall(stall), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_legal(input logic rd, input logic [2:0] f3, input logic [31:0] a);
        int n;
        if (f3 == 3'b011 || f3[2:1] == 2'b11) return 0;
        if (!rd && f3[2]) return 0;
        n = size_bytes(f3);
        return (a % n) == 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int n = size_bytes(f3);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] w);
        case (size_bytes(f3))
            1:       return (w & 32'hFF) * 32'h0101_0101;
            2:       return (w & 32'hFFFF) * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w);
        logic [31:0] v;
        case (f3)
            3'b000: begin v = (w >> (8 * (a % 4))) & 32'hFF;
                          return (v >= 32'h80) ? v - 32'h100 : v; end
            3'b100: return (w >> (8 * (a % 4))) & 32'hFF;
            3'b001: begin v = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
                          return (v >= 32'h8000) ? v - 32'h1_0000 : v; end
            3'b101: return (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    // gd: extra REQ cycles before gnt; rv: extra WAIT cycles before rvalid.
    // spur: drive garbage rvalid during REQ (including the gnt cycle).
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rdat, input int gd, input int rv,
                             input bit spur);
        bit is_ld = rd;
        int done_idx = is_ld ? 3 + gd + rv : 2 + gd;
        bit in_req;
        if (is_ld) exp_mr = model_load(f3, a, rdat);
        stall_cnt = 0;
        for (int c = 0; c <= done_idx; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                MEMrdEn = rd; MEMwrEn = wr; funct3 = f3; ALUres = a; RS2data = wd;
            end
            in_req = (c >= 1) && (c <= 1 + gd);
            dmem_gnt = (c == 1 + gd);
            if (is_ld && c == 2 + gd + rv) begin
                dmem_rvalid = 1'b1; dmem_rdata = rdat;
            end else begin
                dmem_rvalid = spur && in_req;
                dmem_rdata = $urandom;
            end
            @(negedge clk);
            if (stall) stall_cnt++;
            chk("stall", 32'(stall), 32'(c < done_idx));
            chk("mem_err_legal", 32'(mem_err), 32'd0);
            chk("dmem_req", 32'(dmem_req), 32'(in_req));
            if (in_req) begin
                chk("dmem_addr", dmem_addr, a & 32'hFFFF_FFFC);
                chk("dmem_we", 32'(dmem_we), 32'(!is_ld));
                if (!is_ld) begin
                    chk("dmem_be", 32'(dmem_be), 32'(model_be(f3, a)));
                    chk("dmem_wdata", dmem_wdata, model_wdata(f3, wd));
                end
            end
            if (c == done_idx) chk("MEMread_done", MEMread, exp_mr);
        end
        @(posedge clk); #1;
        MEMrdEn = 0; MEMwrEn = 0; dmem_gnt = 0; dmem_rvalid = 0;
    endtask

    task automatic do_illegal(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a);
        @(posedge clk); #1;
        MEMrdEn = rd; MEMwrEn = wr; funct3 = f3; ALUres = a; RS2data = $urandom;
        @(negedge clk);
        chk("ill_mem_err", 32'(mem_err), 32'd1);
        chk("ill_stall", 32'(stall), 32'd0);
        chk("ill_req", 32'(dmem_req), 32'd0);
        chk("ill_memread", MEMread, exp_mr);
        @(posedge clk); #1;
        MEMrdEn = 0; MEMwrEn = 0;
        @(negedge clk);
        chk("ill_err_pulse", 32'(mem_err), 32'd0);
        chk("ill_req_after", 32'(dmem_req), 32'd0);
        chk("ill_memread_after", MEMread, exp_mr);
    endtask

    initial begin
        rst_n = 0; MEMrdEn = 0; MEMwrEn = 0; funct3 = 0; ALUres = 0; RS2data = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_we", 32'(dmem_we), 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_be", 32'(dmem_be), 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_memread", MEMread, 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_err", 32'(mem_err), 0);
        @(posedge clk); #1 rst_n = 1;

        do_access(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0);
        chk("lw_const", MEMread, 32'hDEADBEEF);
        chk("lw_stall_cycles", stall_cnt, 3);

        do_access(1, 0, 3'b000, 32'h103, 0, 32'h80FF_1234, 0, 0, 0);
        chk("lb_const", MEMread, 32'hFFFF_FF80);
        do_access(1, 0, 3'b100, 32'h103, 0, 32'h80FF_1234, 0, 0, 0);
        chk("lbu_const", MEMread, 32'h0000_0080);

        do_access(0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 0, 0, 0, 0);
        chk("sh_memread_hold", MEMread, 32'h0000_0080);

        // gnt on the 4th REQ cycle, rvalid two cycles after gnt
        do_access(1, 0, 3'b010, 32'h300, 0, 32'hCAFE_F00D, 3, 1, 1);
        chk("delayed_stall_cycles", stall_cnt, 7);
        chk("delayed_memread", MEMread, 32'hCAFE_F00D);

        do_access(1, 1, 3'b101, 32'h402, 32'h5555_5555, 32'h9876_1234, 1, 2, 1);

        do_illegal(1, 0, 3'b010, 32'h102);
        do_illegal(0, 1, 3'b001, 32'h201);
        do_illegal(1, 0, 3'b011, 32'h100);
        do_illegal(0, 1, 3'b100, 32'h100);

        for (int i = 0; i < 60; i++) begin
            logic        rd, wr;
            logic [2:0]  f3;
            logic [31:0] a;
            rd = 1'($urandom); wr = ~rd | 1'($urandom);
            f3 = 3'($urandom); a = $urandom;
            if (model_legal(rd, f3, a))
                do_access(rd, wr, f3, a, $urandom, $urandom,
                          $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
            else
                do_illegal(rd, wr, f3, a);
        end

        // reset while in WAIT; the late response must be ignored
        @(posedge clk); #1;
        MEMrdEn = 1; funct3 = 3'b010; ALUres = 32'h500;
        @(posedge clk); #1; dmem_gnt = 1;
        @(posedge clk); #1; dmem_gnt = 0;
        @(negedge clk);
        chk("pre_rst_wait_stall", 32'(stall), 1);
        rst_n = 0; MEMrdEn = 0; exp_mr = 0;
        #1;
        chk("midrst_req", 32'(dmem_req), 0);
        chk("midrst_addr", dmem_addr, 0);
        chk("midrst_memread", MEMread, 0);
        chk("midrst_stall", 32'(stall), 0);
        @(posedge clk); #1 rst_n = 1;
        dmem_rvalid = 1; dmem_rdata = 32'h1357_9BDF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("late_rvalid_memread", MEMread, exp_mr);
        chk("late_rvalid_req", 32'(dmem_req), 0);
        chk("late_rvalid_stall", 32'(stall), 0);
        dmem_rvalid = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit of the five-stage RISC-V lite pipeline. It takes the ALU-computed address and store data from EX/MEM, runs a request/grant/response handshake with the data memory, and produces the aligned, sign- or zero-extended load word (`MEMread`) that the writeback select consumes. It stalls the pipeline while an access is outstanding and flags misaligned or illegal accesses.

## Interface
- `N`, 32: datapath width. Fixed at 32 for RV32; other values are not supported.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `MEMrdEn`  in  1  load in MEM stage (from CU).
- `MEMwrEn`  in  1  store in MEM stage (from CU).
- `funct3`  in  3  access size and signedness.
- `ALUres`  in  N  byte address.
- `RS2data`  in  N  store data.
- `dmem_req`  out  1  request valid.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  N  word-aligned address, with `ALUres[1:0]` cleared.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  N  lane-replicated store data.
- `dmem_gnt`  in  1  request accepted.
- `dmem_rvalid`  in  1  read data valid.
- `dmem_rdata`  in  N  read word.
- `MEMread`  out  N  extracted load data, to writeback.
- `stall`  out  1  hold IF..MEM stages.
- `mem_err`  out  1  one-cycle pulse: misaligned access or illegal `funct3`.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - If `MEMrdEn | MEMwrEn` is set and the access is legal, capture address, byte enables, write data, `we` and `funct3` into registers, assert `stall` (combinational), and go to REQ.
  - If `MEMrdEn` and `MEMwrEn` are both set, the access is a load.
- **Legal accesses**
  - Loads: `funct3` ∈ {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}.
  - Stores: `funct3` ∈ {000 SB, 001 SH, 010 SW}.
  - Halfword accesses need `ALUres[0]`=0. Word accesses need `ALUres[1:0]`=0.
- **Illegal accesses**
  - No request is issued and `stall` stays 0.
  - `mem_err`=1 for that cycle only; state stays IDLE.
  - `MEMread` is unchanged.
- **REQ**
  - `dmem_req`=1, with `dmem_addr`, `dmem_we`, `dmem_be` and `dmem_wdata` held stable from the registered copies.
  - `stall`=1.
  - On `dmem_gnt`: a store goes to DONE, a load goes to WAIT.
- **WAIT**
  - `dmem_req`=0, `stall`=1.
  - `dmem_rvalid` is sampled only in this state.
  - On `rvalid`, register the extracted data into `MEMread` and go to DONE.
- **DONE**
  - `stall`=0 for exactly one cycle, so the pipeline advances.
  - Then go to IDLE unconditionally. The same instruction is never re-issued.
- **Byte enables and store data**
  - SB: `be` = 4'b0001 << `a[1:0]`; `wdata` = byte replicated ×4.
  - SH: `be` = 4'b0011 << `a[1:0]`; `wdata` = halfword replicated ×2.
  - SW: `be` = 4'b1111; `wdata` = `RS2data`.
- **Load extraction**
  - Select the lane at `a[1:0]` (`a[1]` for halfwords).
  - Sign-extend for LB/LH, zero-extend for LBU/LHU; LW passes the word through.
- **Output hold**
  - `MEMread` holds its value until the next load completes; stores never modify it.

## Timing
- **Reset**
  - State IDLE.
  - `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata`, `MEMread` and `mem_err` are all 0; `stall` is 0.
- **Store, zero-wait grant**
  - IDLE (c0), REQ+gnt (c1), DONE (c2).
  - `stall` is high in c0–c1.
- **Load, zero-wait**
  - IDLE (c0), REQ+gnt (c1), WAIT+rvalid (c2), DONE (c3).
  - `MEMread` is valid from c3.
- **Handshake ordering**
  - `rvalid` is never expected in the same cycle as `gnt`; if asserted there, it is ignored.
  - There is no timeout: REQ and WAIT wait indefinitely.
- **Reset mid-operation**
  - `dmem_req` drops immediately and the FSM returns to IDLE.
  - Any outstanding response after reset is ignored, because it arrives outside WAIT.
- **Outputs**
  - `stall` is combinational from state and inputs.
  - All `dmem_*` outputs and `MEMread` are registered.

## Structure
- **Package `lsu_pkg`**
  - State enum.
  - `funct3` constants: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - Function `be_gen(funct3, addr[1:0])`.
- **Sub-module `load_extract`**
  - Combinational.
  - Inputs: `rdata`, `funct3`, `addr[1:0]`.
  - Output: the extended N-bit word.

## Test plan
- **LW, zero-wait**
  - Stimulus: LW at 0x100; memory returns 0xDEADBEEF one cycle after `gnt`.
  - Required response: `MEMread`=0xDEADBEEF in DONE; `stall` high for exactly 3 cycles.
- **LB, sign-extend**
  - Stimulus: LB at 0x103; `rdata`=0x80FF_1234.
  - Required response: `MEMread`=0xFFFF_FF80.
  - Same word as LBU at 0x103: `MEMread`=0x0000_0080.
- **SH, lane select**
  - Stimulus: SH at 0x202 with `RS2data`=0x1234_ABCD.
  - Required response: `dmem_be`=4'b1100, `dmem_wdata`=0xABCD_ABCD, `dmem_addr`=0x200, `dmem_we`=1.
- **Delayed grant and response**
  - Stimulus: `gnt` delayed 3 cycles, `rvalid` delayed 2 cycles.
  - Required response: request fields stable throughout REQ; `stall` high for 7 cycles; `MEMread` correct.
- **Illegal accesses**
  - Stimulus: LW at 0x102; SH at 0x201; load with `funct3`=011.
  - Required response, each case: `mem_err` pulses 1 cycle, `dmem_req` stays 0, `stall`=0, `MEMread` unchanged.
- **Reset mid-operation**
  - Stimulus: `rst_n` low while in WAIT, then `rvalid` arrives after release.
  - Required response: all outputs 0 immediately; late `rvalid` does not change `MEMread`.
